// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with prioritised redirects.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit #(
  parameter int unsigned WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall_i,
  input  logic             exc_i,
  input  logic             branch_i,
  input  logic [WIDTH-1:0] branch_target_i,
  input  logic             jump_i,
  input  logic [WIDTH-1:0] jump_target_i,
  input  logic             call_i,
  input  logic             ret_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_plus4_o,
  output logic             pc_valid_o,
  output logic             align_err_o,
  output logic             ras_empty_o
);

  localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VECTOR);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic             valid_q;
  logic             align_q;
  logic             align_d;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] ras_top;
  logic             ras_hit;
  logic             hold;
  logic             take_exc;
  logic             take_br;
  logic             take_jmp;

  assign pc_o        = pc_q;
  assign pc_plus4_o  = pc_q + WIDTH'(4);
  assign pc_valid_o  = valid_q;
  assign align_err_o = align_q;

  // nothing moves until the first post-reset edge has raised valid
  assign take_exc = valid_q & exc_i;
  assign hold     = ~valid_q | (~exc_i & stall_i);
  assign take_br  = valid_q & ~exc_i & ~stall_i & branch_i;
  assign take_jmp = valid_q & ~exc_i & ~stall_i
                  & ~branch_i & jump_i;

`ifdef PC_RAS_EN
  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    ras_ptr;
  logic [PW:0]      ras_cnt;
  logic [PW-1:0]    top_idx;
  logic             push;

  assign top_idx     = ras_ptr - 1'b1;
  assign ras_top     = ras_mem[top_idx];
  assign ras_hit     = take_jmp & ret_i & (ras_cnt != '0);
  assign push        = take_jmp & call_i;
  assign ras_empty_o = (ras_cnt == '0);

  // stack pointer and occupancy; call+ret replaces the top in place
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (push & ras_hit) begin
      ras_ptr <= ras_ptr;
    end else if (push) begin
      ras_ptr <= ras_ptr + 1'b1;
      if (ras_cnt != FULL) ras_cnt <= ras_cnt + 1'b1;
    end else if (ras_hit) begin
      ras_ptr <= top_idx;
      ras_cnt <= ras_cnt - 1'b1;
    end
  end

  // link storage; a full stack overwrites the oldest slot at ras_ptr
  always_ff @(posedge clk) begin
    if (push) ras_mem[ras_hit ? top_idx : ras_ptr] <= pc_plus4_o;
  end
`else
  logic unused_ras;
  assign unused_ras  = ^{call_i, ret_i};
  assign ras_top     = jump_target_i;
  assign ras_hit     = 1'b0;
  assign ras_empty_o = 1'b1;
`endif

  // next-PC selection and alignment check on the raw target
  always_comb begin
    raw     = jump_target_i;
    pc_d    = pc_plus4_o;
    align_d = 1'b0;
    unique case (1'b1)
      take_br: raw = branch_target_i;
      ras_hit: raw = ras_top;
      default: raw = jump_target_i;
    endcase
    unique case (1'b1)
      hold:     pc_d = pc_q;
      take_exc: pc_d = EXC_PC;
      take_br, take_jmp: begin
        pc_d    = {raw[WIDTH-1:2], 2'b00};
        align_d = |raw[1:0];
      end
      default:  pc_d = pc_plus4_o;
    endcase
  end

  // PC, start-up valid flag and alignment pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RST_PC;
      valid_q <= 1'b0;
      align_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
      align_q <= align_d;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for pc_unit.
// Reference model keeps the return stack as a bounded queue.
module tb_pc_unit;

  localparam logic [31:0] RV    = 32'h0040_0000;
  localparam logic [31:0] EV    = 32'h8000_0180;
  localparam int          DEPTH = 4;
`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        exc_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        jump_i = 1'b0;
  logic [31:0] jump_target_i = '0;
  logic        call_i = 1'b0;
  logic        ret_i = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        pc_valid_o;
  logic        align_err_o;
  logic        ras_empty_o;

  pc_unit #(
    .WIDTH(32),
    .RESET_VECTOR(RV),
    .EXC_VECTOR(EV),
    .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .stall_i(stall_i),
    .exc_i(exc_i),
    .branch_i(branch_i),
    .branch_target_i(branch_target_i),
    .jump_i(jump_i),
    .jump_target_i(jump_target_i),
    .call_i(call_i),
    .ret_i(ret_i),
    .pc_o(pc_o),
    .pc_plus4_o(pc_plus4_o),
    .pc_valid_o(pc_valid_o),
    .align_err_o(align_err_o),
    .ras_empty_o(ras_empty_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        v;
    logic        ae;
    logic        re;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc = RV;
  bit          m_v = 1'b0;
  bit          m_ae = 1'b0;
  logic [31:0] m_stk[$];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.pc = m_pc;
    e.v  = m_v;
    e.ae = m_ae;
    e.re = (m_stk.size() == 0);
    return e;
  endfunction

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset_n = 1'b0;
      {stall_i, exc_i, branch_i, jump_i, call_i, ret_i} = '0;
      m_pc = RV;
      m_v  = 1'b0;
      m_ae = 1'b0;
      m_stk.delete();
      sb.push_back(snap());
    end
  endtask

  task automatic step(input bit st, input bit ex, input bit br,
                      input logic [31:0] bt, input bit jp,
                      input logic [31:0] jt, input bit cl,
                      input bit rt);
    logic [31:0] tgt;
    logic [31:0] link;
    @(negedge clk);
    reset_n = 1'b1;
    stall_i = st;
    exc_i = ex;
    branch_i = br;
    branch_target_i = bt;
    jump_i = jp;
    jump_target_i = jt;
    call_i = cl;
    ret_i = rt;
    if (!m_v) begin
      m_v  = 1'b1;
      m_ae = 1'b0;
    end else if (ex) begin
      m_pc = EV;
      m_ae = 1'b0;
    end else if (st) begin
      m_ae = 1'b0;
    end else if (br) begin
      m_pc = bt & 32'hFFFF_FFFC;
      m_ae = (bt % 4) != 0;
    end else if (jp) begin
      tgt  = jt;
      link = m_pc + 4;
      if (RAS_ON && rt && m_stk.size() > 0)
        tgt = m_stk.pop_back();
      if (RAS_ON && cl) begin
        m_stk.push_back(link);
        if (m_stk.size() > DEPTH) void'(m_stk.pop_front());
      end
      m_pc = tgt & 32'hFFFF_FFFC;
      m_ae = (tgt % 4) != 0;
    end else begin
      m_pc = m_pc + 4;
      m_ae = 1'b0;
    end
    sb.push_back(snap());
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic jmp(input logic [31:0] t, input bit cl,
                     input bit rt);
    step(0, 0, 0, 0, 1, t, cl, rt);
  endtask

  // monitor: compare every presented cycle against the queue head
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc", pc_o, e.pc);
        chk("pc_plus4", pc_plus4_o, e.pc + 32'd4);
        chk("valid", {31'd0, pc_valid_o}, {31'd0, e.v});
        chk("align_err", {31'd0, align_err_o}, {31'd0, e.ae});
        chk("ras_empty", {31'd0, ras_empty_o}, {31'd0, e.re});
      end
    end
  end

  initial begin
    do_reset(2);
    repeat (3) idle();
    jmp(32'h100, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h200, 1, 32'h300, 0, 0);
    jmp(32'h302, 0, 0);
    idle();
    jmp(32'hFFFF_FFFC, 0, 0);
    repeat (2) idle();
    jmp(32'h10, 0, 0);
    jmp(32'h20, 1, 0);
    jmp(32'h30, 1, 0);
    jmp(32'h40, 1, 0);
    jmp(32'h50, 1, 0);
    jmp(32'h1000, 1, 0);
    repeat (5) jmp(32'hDEAD_0000, 0, 1);
    jmp(32'h10, 0, 0);
    jmp(32'h20, 1, 0);
    jmp(32'h30, 1, 0);
    do_reset(1);
    idle();
    jmp(32'hBEEF_0000, 0, 1);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) begin
        do_reset($urandom_range(2, 1));
      end else begin
        step($urandom_range(9) == 0, $urandom_range(19) == 0,
             $urandom_range(7) == 0, $urandom,
             $urandom_range(2) == 0,
             ($urandom_range(3) == 0) ? $urandom
                                      : ($urandom & 32'hFFFC),
             $urandom_range(2) == 0, $urandom_range(2) == 0);
      end
    end
    idle();
    repeat (3) @(posedge clk);
    #2;
    chk("drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter register for the pipelined MIPS datapath, replacing the combinational pass-through PC. It holds the fetch address, advances it by 4 each cycle, and handles stall, branch, jump, return and exception redirects with fixed priority. An optional return-address stack predicts `jr $ra` targets. It sits at the head of the fetch stage and drives the instruction-memory address.

## Interface
Parameters:
- `WIDTH`, 32: PC width in bits; must be ≥ 8.
- `RESET_VECTOR`, 32'h0000_0000: PC value while in reset; truncated to `WIDTH`.
- `EXC_VECTOR`, 32'h8000_0180: exception handler address; truncated to `WIDTH`.
- `RAS_DEPTH`, 4: return-address-stack entries; power of two, 2 to 16. Used only with `PC_RAS_EN`.

Ports:
- `clk`, in, 1: clock; all state changes on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `stall_i`, in, 1: hold the PC; blocks every update except an exception.
- `exc_i`, in, 1: exception redirect to `EXC_VECTOR`.
- `branch_i`, in, 1: taken-branch redirect.
- `branch_target_i`, in, `WIDTH`: branch target.
- `jump_i`, in, 1: jump redirect (j/jal/jr).
- `jump_target_i`, in, `WIDTH`: jump target, and fallback return target.
- `call_i`, in, 1: the current jump is a jal; push the link address.
- `ret_i`, in, 1: the current jump is a `jr $ra`.
- `pc_o`, out, `WIDTH`: current fetch address.
- `pc_plus4_o`, out, `WIDTH`: `pc_o + 4`, modulo 2^WIDTH; combinational.
- `pc_valid_o`, out, 1: `pc_o` is a fetchable address.
- `align_err_o`, out, 1: one-cycle pulse; the accepted target had nonzero bits [1:0].
- `ras_empty_o`, out, 1: the return-address stack is empty. Tied to 1 without `PC_RAS_EN`.

## Operation
- On each edge, the next PC is selected by priority, highest first:
  1. `exc_i` selects `EXC_VECTOR`. This applies even when `stall_i` is high.
  2. `stall_i` holds the PC.
  3. `branch_i` selects `branch_target_i`.
  4. `jump_i` with `ret_i` selects the return target.
  5. `jump_i` selects `jump_target_i`.
  6. Otherwise the PC advances to `pc_o + 4`.
- Targets from branch, jump and return are written with bits [1:0] forced to 0.
  - If the raw target had nonzero bits [1:0], `align_err_o` is 1 for the following cycle.
  - `EXC_VECTOR` never sets `align_err_o`.
- Sequential increment wraps at 2^WIDTH. For example, 32'hFFFF_FFFC advances to 0.
- `call_i` and `ret_i` are ignored unless `jump_i` is high and that jump is the selected source.
- `pc_valid_o` start-up behaviour:
  - It is 0 in reset.
  - It becomes 1 on the first rising edge after `reset_n` deasserts.
  - That first edge does not advance the PC, so `RESET_VECTOR` is presented with `pc_valid_o` = 1 for at least one cycle.
  - No PC update occurs while `pc_valid_o` is 0.

## Timing
- The PC register has one cycle of latency: a redirect asserted in cycle N appears on `pc_o` in cycle N+1.
- Reset values, applied immediately when `reset_n` falls:
  - `pc_o` = `RESET_VECTOR`
  - `pc_valid_o` = 0
  - `align_err_o` = 0
  - `ras_empty_o` = 1
  - RAS pointer and count = 0
- Reset in the middle of operation discards all stack contents and any pending redirect.
- All inputs are sampled at the rising edge only; glitches between edges have no effect.

## Configuration
- Macro `PC_RAS_EN`.
- Defined: a circular stack of `RAS_DEPTH` entries is compiled in.
  - An accepted call pushes `pc_o + 4`.
  - An accepted return pops the top entry and uses it as the target.
  - Return on an empty stack uses `jump_target_i`; the count stays 0.
  - Push on a full stack overwrites the oldest entry; the count stays at `RAS_DEPTH`.
  - Call and return in the same accepted jump: return to the popped entry, then push the new link. The net count is unchanged.
  - An exception or stall leaves the stack untouched.
- Undefined: no stack storage exists.
  - A return always uses `jump_target_i`.
  - `call_i` is ignored.
  - `ras_empty_o` is constant 1.

## Test plan
- Reset release with `RESET_VECTOR` = 0x0040_0000:
  - Cycle 0 after release: `pc_o` = 0x0040_0000, `pc_valid_o` = 1.
  - Following cycles: 0x0040_0004, then 0x0040_0008.
- Stall plus exception: `stall_i` = 1 for 3 cycles at 0x100 holds `pc_o` at 0x100. Asserting `exc_i` during the stall gives 0x8000_0180 on the next cycle.
- Branch versus jump: `branch_i` and `jump_i` asserted together with targets 0x200 and 0x300 give `pc_o` = 0x200. Jump target 0x302 gives `pc_o` = 0x300 with `align_err_o` pulsed for one cycle.
- Wrap-around: PC at 0xFFFF_FFFC advances to 0x0000_0000.
- RAS (with `PC_RAS_EN`, depth 4):
  - Five calls from PCs 0x10, 0x20, 0x30, 0x40, 0x50, then five returns with `jump_target_i` = 0xDEAD_0000, give targets 0x54, 0x44, 0x34, 0x24, then 0xDEAD_0000.
  - `ras_empty_o` rises after the fourth return.
- Reset mid-call: two pushes, then `reset_n` low for one cycle gives `ras_empty_o` = 1. A subsequent return uses `jump_target_i`.
